// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operand width, opcode encodings and FSM states.
package muldiv_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage request and HI/LO result bundle between the pipeline and the
// multiply/divide unit.
interface ex_muldiv_unit_if #(
  parameter int WIDTH = muldiv_pkg::WIDTH
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] RSdata_i;
  logic [WIDTH-1:0] RTdata_i;
  logic             flush_i;
  logic             busy_o;
  logic             done_o;
  logic             div_by_zero_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, RSdata_i, RTdata_i, flush_i,
    input  busy_o, done_o, div_by_zero_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, RSdata_i, RTdata_i, flush_i,
    output busy_o, done_o, div_by_zero_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_muldiv_unit_sign_fix.sv
// Combinational two's-complement conditional negate; serves as abs() when
// i_neg is the operand's own sign bit.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);
  assign o_val = i_neg ? ((~i_val) + W'(1)) : i_val;
endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative 32-step shift-add multiplier / restoring divider writing HI/LO,
// with stall (busy) and flush handling for the EX stage.
module ex_muldiv_unit #(
  parameter int WIDTH = muldiv_pkg::WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  ex_muldiv_unit_if.slave  bus
);
  import muldiv_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);

  state_e             r_state;
  op_e                r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic               r_neg_res;
  logic               r_rs_neg;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;

  logic [WIDTH-1:0]   w_in  [2];
  logic [WIDTH-1:0]   w_mag [2];

  assign w_in[0] = bus.RSdata_i;
  assign w_in[1] = bus.RTdata_i;

  // Signed opcodes have op_i[0] set; unsigned operands pass through unchanged.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_abs
      muldiv_sign_fix #(.W(WIDTH)) u_abs (
        .i_val (w_in[gi]),
        .i_neg (bus.op_i[0] & w_in[gi][WIDTH-1]),
        .o_val (w_mag[gi])
      );
    end
  endgenerate

  // Multiply: acc = {partial product, remaining multiplier bits}.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; shifted remainder needs one extra bit.
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_rem_sub;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_next;
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge       = (w_rem_sh >= {1'b0, r_opb});
  assign w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_opb;
  assign w_div_next = {(w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (.i_val(r_acc), .i_neg(r_neg_res), .o_val(w_prod));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (.i_val(r_acc[WIDTH-1:0]), .i_neg(r_neg_res), .o_val(w_quo));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (.i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_rs_neg), .o_val(w_rem));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= IDLE;
      r_op      <= OP_MULTU;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_neg_res <= 1'b0;
      r_rs_neg  <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start_i && !bus.flush_i) begin
            r_op      <= op_e'(bus.op_i);
            r_cnt     <= '0;
            r_dbz     <= 1'b0;
            r_acc     <= {{WIDTH{1'b0}}, w_mag[0]};
            r_opb     <= w_mag[1];
            r_rs_neg  <= bus.op_i[0] & bus.RSdata_i[WIDTH-1];
            r_neg_res <= bus.op_i[0] & (bus.RSdata_i[WIDTH-1] ^ bus.RTdata_i[WIDTH-1]);
            if (bus.op_i[1] && (bus.RTdata_i == '0)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= CALC;
              r_busy  <= 1'b1;
            end
          end
        end
        CALC: begin
          if (bus.flush_i) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= r_op[1] ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH-1)) r_state <= FIX;
          end
        end
        FIX: begin
          r_busy <= 1'b0;
          if (bus.flush_i) begin
            r_state <= IDLE;
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
            if (r_op[1]) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              {r_hi, r_lo} <= w_prod;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o        = r_busy;
  assign bus.done_o        = r_done;
  assign bus.div_by_zero_o = r_dbz;
  assign bus.hi_o          = r_hi;
  assign bus.lo_o          = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed mul/div vectors, latency,
// divide-by-zero, flush and asynchronous reset checks.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_unit_if bus ();

  ex_muldiv_unit dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done_o) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done_o=1 expected no result pending");
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("result hi=%h lo=%h dbz=%0b (exp %h %h %0b)",
                 bus.hi_o, bus.lo_o, bus.div_by_zero_o, e.hi, e.lo, e.dbz);
        chk("hi", 64'(bus.hi_o), 64'(e.hi));
        chk("lo", 64'(bus.lo_o), 64'(e.lo));
        chk("dbz", 64'(bus.div_by_zero_o), 64'(e.dbz));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                       input int exp_done_k, input int exp_busy);
    int done_k;
    int busy_n;
    exp_t e;
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.op_i     = op;
    bus.RSdata_i = a;
    bus.RTdata_i = b;
    e.hi = ehi; e.lo = elo; e.dbz = edbz;
    q.push_back(e);
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    done_k = 0;
    busy_n = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.busy_o) busy_n++;
      if (bus.done_o) begin
        done_k = k;
        break;
      end
    end
    chk("done_cycle", 64'(done_k), 64'(exp_done_k));
    chk("busy_cycles", 64'(busy_n), 64'(exp_busy));
  endtask

  initial begin
    bus.start_i  = 1'b0;
    bus.op_i     = 2'b00;
    bus.RSdata_i = '0;
    bus.RTdata_i = '0;
    bus.flush_i  = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_hi", 64'(bus.hi_o), 64'h0);
    chk("rst_lo", 64'(bus.lo_o), 64'h0);
    chk("rst_busy", 64'(bus.busy_o), 64'h0);
    chk("rst_done", 64'(bus.done_o), 64'h0);
    chk("rst_dbz", 64'(bus.div_by_zero_o), 64'h0);

    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 33);
    issue(OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34, 33);
    issue(OP_MULT,  32'd7,        32'd6,        32'h0,        32'd42,       1'b0, 34, 33);
    issue(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 33);
    issue(OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 34, 33);
    issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 34, 33);
    issue(OP_MULTU, 32'h80000001, 32'd2,        32'd1,        32'd2,        1'b0, 34, 33);
    issue(OP_DIVU,  32'd100,      32'd0,        32'd1,        32'd2,        1'b1, 1,  0);
    issue(OP_MULTU, 32'd9,        32'd9,        32'd0,        32'd81,       1'b0, 34, 33);

    // Flush mid-CALC; the start at T+5 must be ignored.
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.op_i     = OP_MULTU;
    bus.RSdata_i = 32'd3;
    bus.RTdata_i = 32'd4;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      bus.start_i = (k == 5);
      bus.flush_i = (k == 10);
      if (k == 9) chk("flush_busy_before", 64'(bus.busy_o), 64'h1);
      if (k == 11) begin
        chk("flush_busy_after", 64'(bus.busy_o), 64'h0);
        chk("flush_hi_kept", 64'(bus.hi_o), 64'h0);
        chk("flush_lo_kept", 64'(bus.lo_o), 64'd81);
      end
    end
    issue(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34, 33);

    // Asynchronous reset in the middle of CALC, away from any clock edge.
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.op_i     = OP_MULTU;
    bus.RSdata_i = 32'd5;
    bus.RTdata_i = 32'd5;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", 64'(bus.busy_o), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", 64'(bus.hi_o), 64'h0);
    chk("arst_lo", 64'(bus.lo_o), 64'h0);
    chk("arst_busy", 64'(bus.busy_o), 64'h0);
    chk("arst_done", 64'(bus.done_o), 64'h0);
    chk("arst_dbz", 64'(bus.div_by_zero_o), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("pending_results", 64'(q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative multiply/divide unit on the consumer side of the ID/EX pipeline register. It takes RS/RT operand data and a mul/div opcode from EX, runs a 32-step shift-add multiply or restoring divide, and writes the HI/LO registers. While it computes, it asserts busy_o so the hazard unit stalls IF/ID and bubbles ID/EX. A flush input lets branch or exception logic abort an operation in flight.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits and the iteration count equals WIDTH.

Ports:
clk_i  input  1  clock; all state changes on the rising edge
rst_n_i  input  1  asynchronous, active-low reset
start_i  input  1  EX issues a mul/div this cycle; sampled only in IDLE
op_i  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
RSdata_i  input  WIDTH  multiplicand or dividend
RTdata_i  input  WIDTH  multiplier or divisor
flush_i  input  1  abort the current operation
busy_o  output  1  stall request to the hazard unit
done_o  output  1  one-cycle pulse when HI/LO have just been updated
div_by_zero_o  output  1  set by a divide with RTdata_i=0; cleared at the next accepted start
hi_o  output  WIDTH  HI register: high product, or remainder
lo_o  output  WIDTH  LO register: low product, or quotient

Behaviour:
- Reset (async assert, sync deassert by the clock domain): state=IDLE; hi_o, lo_o, counter and working registers=0; busy_o=0; done_o=0; div_by_zero_o=0.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start_i=1 and flush_i=0 -> latch op, latch magnitudes of the operands (signed ops only), latch sign flags, counter=0, clear div_by_zero_o.
  - Next state: CALC, except a divide with RTdata_i=0 -> DONE.
- CALC: one iteration per cycle; counter increments; after iteration WIDTH-1 -> FIX.
  - Multiply: 2*WIDTH-bit accumulator; add the multiplicand when the current multiplier LSB is 1, then shift.
  - Divide: restoring; shift the {remainder, quotient} pair left, trial-subtract the divisor, set the quotient bit when the result is non-negative.
- FIX: sign correction for signed ops.
  - MULT: negate the 64-bit product when the operand signs differ.
  - DIV: negate the quotient when the signs differ; the remainder takes the dividend's sign.
  - Load hi_o/lo_o at the edge leaving FIX -> DONE.
- DONE: done_o=1 for exactly one cycle, then -> IDLE unconditionally.
- Divide-by-zero: enter DONE at T+1 with div_by_zero_o=1; hi_o/lo_o unchanged; busy_o never asserted.
- Latency: start accepted in cycle T -> CALC during T+1..T+32, FIX at T+33, done_o at T+34; hi_o/lo_o valid from T+34 on.
- busy_o=1 exactly in CALC and FIX. Registered, no combinational path from start_i.
- Back-to-back: a new start is accepted in the IDLE cycle that follows DONE, at T+35.
- start_i outside IDLE is ignored; no queueing.
- flush_i in CALC or FIX: -> IDLE next edge; hi_o/lo_o keep their previous values; no done_o pulse.
- flush_i in IDLE with start_i: flush wins and start is dropped.
- flush_i in DONE has no effect; the result is already committed.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This is the natural wrap result; no trap.
- Reset mid-operation: immediate return to reset values, including hi_o/lo_o=0.

Decomposition:
- Package muldiv_pkg holds: op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV), the state enum (IDLE/CALC/FIX/DONE), and WIDTH.
- One sub-module, muldiv_sign_fix: a combinational abs/negate helper. It is used at operand latch and in FIX.
- FSM, counter and iteration datapath stay in ex_muldiv_unit.

Test Plan:
1. Hold rst_n_i=0, then release -> hi_o=lo_o=0, busy_o=0, done_o=0, div_by_zero_o=0; an asynchronous assert mid-CALC clears everything within the same cycle.
2. MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at T -> busy_o high T+1..T+33, done_o at T+34, HI=0xFFFFFFFE, LO=0x00000001.
3. MULT 0xFFFFFFFD (-3) x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; then a back-to-back MULT 7 x 6 started at T+35 -> HI=0, LO=42.
4. DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 2 -> LO=3, HI=1; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
5. DIVU 100 / 0 with HI/LO previously 1/2 -> done_o at T+1, div_by_zero_o=1, HI=1, LO=2, busy_o stays 0; the next start clears div_by_zero_o.
6. Start MULTU 3 x 4, pulse flush_i at T+10 and start_i again at T+5 -> IDLE at T+11, no done_o, HI/LO unchanged; a new start at T+12 completes normally at T+46.
